// File: rtl/note_recorder.sv
// note_recorder
//   Records the lesson-mode note stream as run-length entries {note, dur}
//   (dur counted in quarter beats) and replays the buffer on command.
//   The replayed note is one of the autoplay sources at the top-level note mux.
//
//   Optional build macro: NOTE_RECORDER_TRIM_REST_EN
//     When defined, rest ticks seen before the first real note of a recording
//     are discarded. Interior and trailing rests are still recorded.
//
// Ports
//   CLK           system clock
//   RESET         synchronous, active-low reset
//   QUARTER_BEAT  beat clock level; its rising edge is the beat tick
//   REC/PLAY/STOP one-cycle command pulses (priority STOP > REC > PLAY)
//   note_in       live lesson-mode note, sampled only on beat ticks
//   note_out      replayed note, REST_NOTE when not playing
//   recording     high while recording
//   playing       high while loading or sounding a replay entry
//   full          buffer holds DEPTH entries
//   count         number of stored entries
module note_recorder #(
    parameter int DEPTH     = 32,
    parameter int DUR_W     = 6,
    parameter int NOTE_W    = 4,
    parameter int REST_NOTE = 0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     QUARTER_BEAT,
    input  logic                     REC,
    input  logic                     PLAY,
    input  logic                     STOP,
    input  logic [NOTE_W-1:0]        note_in,
    output logic [NOTE_W-1:0]        note_out,
    output logic                     recording,
    output logic                     playing,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = NOTE_W + DUR_W;
    localparam logic [DUR_W-1:0]  DUR_MAX = '1;
    localparam logic [NOTE_W-1:0] REST    = NOTE_W'(REST_NOTE);
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY_LOAD, S_PLAY} state_t;

    state_t            r_state;
    logic              r_beat_d;
    logic              r_cur_valid;
    logic [NOTE_W-1:0] r_cur_note;
    logic [DUR_W-1:0]  r_dur;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic [AW-1:0]     r_rd_ptr;
    logic [DUR_W-1:0]  r_remain;
    logic [NOTE_W-1:0] r_note_out;
    logic [EW-1:0]     r_mem [DEPTH];
    logic [EW-1:0]     r_rd_data;

    logic              w_tick;
    logic              w_in_rec;
    logic              w_same;
    logic              w_start_ok;
    logic              w_wr_stop;
    logic              w_wr_tick;
    logic              w_wr_en;
    logic [CW-1:0]     w_count_inc;
    logic              w_last;
    logic              w_play_go;
    logic              w_advance;
    logic [AW-1:0]     w_rd_addr;
    logic [NOTE_W-1:0] w_ent_note;
    logic [DUR_W-1:0]  w_ent_dur;

    assign w_tick      = QUARTER_BEAT & ~r_beat_d;
    assign w_in_rec    = (r_state == S_REC);
    // Current run simply extends: same note and duration not yet saturated.
    assign w_same      = r_cur_valid && (note_in == r_cur_note) && (r_dur != DUR_MAX);
`ifdef NOTE_RECORDER_TRIM_REST_EN
    assign w_start_ok  = (note_in != REST);
`else
    assign w_start_ok  = 1'b1;
`endif
    assign w_wr_stop   = w_in_rec & STOP & r_cur_valid & ~r_full;
    assign w_wr_tick   = w_in_rec & ~STOP & w_tick & r_cur_valid & ~w_same;
    assign w_wr_en     = w_wr_stop | w_wr_tick;
    assign w_count_inc = r_count + CW'(1);
    assign w_last      = ({1'b0, r_rd_ptr} == (r_count - CW'(1)));
    assign w_play_go   = (r_state == S_IDLE) & ~STOP & ~REC & PLAY & (r_count != '0);
    assign w_advance   = (r_state == S_PLAY) & ~STOP & w_tick &
                         (r_remain == DUR_W'(1)) & ~w_last;
    // Read address is issued with the transition into PLAY_LOAD so the
    // registered read data is ready when PLAY_LOAD executes.
    assign w_rd_addr   = w_play_go ? '0 : (r_rd_ptr + AW'(1));
    assign w_ent_note  = r_rd_data[EW-1:DUR_W];
    assign w_ent_dur   = r_rd_data[DUR_W-1:0];

    // Buffer storage: contents are don't-care after reset, so no reset here.
    always_ff @(posedge CLK) begin
        if (w_wr_en)
            r_mem[r_count[AW-1:0]] <= {r_cur_note, r_dur};
        if (w_play_go || w_advance)
            r_rd_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_beat_d    <= 1'b1;
            r_cur_valid <= 1'b0;
            r_cur_note  <= REST;
            r_dur       <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_rd_ptr    <= '0;
            r_remain    <= '0;
            r_note_out  <= REST;
        end else begin
            r_beat_d <= QUARTER_BEAT;
            case (r_state)
                S_IDLE: begin
                    if (!STOP) begin
                        if (REC) begin
                            r_state     <= S_REC;
                            r_count     <= '0;
                            r_full      <= 1'b0;
                            r_cur_valid <= 1'b0;
                        end else if (w_play_go) begin
                            r_rd_ptr <= '0;
                            r_state  <= S_PLAY_LOAD;
                        end
                    end
                end
                S_REC: begin
                    if (STOP) begin
                        r_state     <= S_IDLE;
                        r_cur_valid <= 1'b0;
                        if (w_wr_stop) begin
                            r_count <= w_count_inc;
                            r_full  <= (w_count_inc == DEPTH_C);
                        end
                    end else if (w_tick) begin
                        if (!r_cur_valid) begin
                            if (w_start_ok) begin
                                r_cur_note  <= note_in;
                                r_dur       <= DUR_W'(1);
                                r_cur_valid <= 1'b1;
                            end
                        end else if (w_same) begin
                            r_dur <= r_dur + DUR_W'(1);
                        end else begin
                            r_count <= w_count_inc;
                            if (w_count_inc == DEPTH_C) begin
                                // Buffer just filled: the run that would start now is dropped.
                                r_full      <= 1'b1;
                                r_state     <= S_IDLE;
                                r_cur_valid <= 1'b0;
                            end else begin
                                r_cur_note <= note_in;
                                r_dur      <= DUR_W'(1);
                            end
                        end
                    end
                end
                S_PLAY_LOAD: begin
                    if (STOP) begin
                        r_state    <= S_IDLE;
                        r_note_out <= REST;
                    end else begin
                        r_note_out <= w_ent_note;
                        r_remain   <= w_ent_dur;
                        r_state    <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (STOP) begin
                        r_state    <= S_IDLE;
                        r_note_out <= REST;
                    end else if (w_tick) begin
                        if (r_remain == DUR_W'(1)) begin
                            if (w_last) begin
                                r_state    <= S_IDLE;
                                r_note_out <= REST;
                            end else begin
                                r_rd_ptr <= r_rd_ptr + AW'(1);
                                r_state  <= S_PLAY_LOAD;
                            end
                        end else begin
                            r_remain <= r_remain - DUR_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign note_out  = r_note_out;
    assign recording = (r_state == S_REC);
    assign playing   = (r_state == S_PLAY_LOAD) || (r_state == S_PLAY);
    assign full      = r_full;
    assign count     = r_count;

endmodule

// File: tb/tb_note_recorder.sv
// Self-checking bench for note_recorder (default parameters).
// Expected entries come from a run-length model of the per-tick note samples.
module tb_note_recorder;

    localparam int DEPTH = 32;
    localparam int MAXD  = 63;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       QUARTER_BEAT = 1'b0;
    logic       REC = 1'b0;
    logic       PLAY = 1'b0;
    logic       STOP = 1'b0;
    logic [3:0] note_in = 4'd0;
    logic [3:0] note_out;
    logic       recording;
    logic       playing;
    logic       full;
    logic [5:0] count;

    int n_tests = 0;
    int n_fail  = 0;
    int samples[$];
    int exp_note[$];
    int exp_dur[$];
    bit exp_overflow;

    always #5 CLK = ~CLK;

    note_recorder dut (
        .CLK(CLK), .RESET(RESET), .QUARTER_BEAT(QUARTER_BEAT),
        .REC(REC), .PLAY(PLAY), .STOP(STOP), .note_in(note_in),
        .note_out(note_out), .recording(recording), .playing(playing),
        .full(full), .count(count)
    );

    task automatic cyc();
        @(negedge CLK);
    endtask

    // One beat: rising edge, 2 cycles high, 2 cycles low. Returns the note
    // sounding in the tick cycle.
    task automatic beat(output logic [3:0] seen);
        QUARTER_BEAT = 1'b1;
        seen = note_out;
        cyc(); cyc();
        QUARTER_BEAT = 1'b0;
        cyc(); cyc();
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        repeat (3) cyc();
        RESET = 1'b1;
    endtask

    // Run-length model of the sample list, truncated at buffer capacity.
    task automatic model_build();
        exp_note.delete();
        exp_dur.delete();
        foreach (samples[i]) begin
`ifdef NOTE_RECORDER_TRIM_REST_EN
            if (exp_note.size() == 0 && samples[i] == 0) continue;
`endif
            if (exp_note.size() == 0 || exp_note[exp_note.size()-1] != samples[i] ||
                exp_dur[exp_dur.size()-1] == MAXD) begin
                exp_note.push_back(samples[i]);
                exp_dur.push_back(1);
            end else begin
                exp_dur[exp_dur.size()-1] += 1;
            end
        end
        exp_overflow = (exp_note.size() > DEPTH);
        while (exp_note.size() > DEPTH) begin
            void'(exp_note.pop_back());
            void'(exp_dur.pop_back());
        end
    endtask

    // Records the sample list with noise on note_in between ticks.
    task automatic record(input string name);
        logic [3:0] seen;
        REC = 1'b1; cyc(); REC = 1'b0;
        foreach (samples[i]) begin
            note_in = 4'(samples[i]);
            beat(seen);
            note_in = 4'($urandom_range(0, 15));
            cyc();
        end
        n_tests++;
        if (recording !== !exp_overflow) begin
            n_fail++;
            $display("FAIL %s rec_before_stop: got %b want %b", name, recording, !exp_overflow);
        end
        STOP = 1'b1; cyc(); STOP = 1'b0; cyc();
        n_tests++;
        if (count !== 6'(exp_note.size())) begin
            n_fail++;
            $display("FAIL %s count: got %0d want %0d", name, count, exp_note.size());
        end
        n_tests++;
        if (full !== (exp_note.size() == DEPTH) || recording !== 1'b0) begin
            n_fail++;
            $display("FAIL %s full/rec: got %b/%b want %b/0", name, full, recording,
                     exp_note.size() == DEPTH);
        end
    endtask

    // Replays and checks note_out at every tick against the expected entries.
    task automatic play_check(input string name);
        logic [3:0] seen;
        PLAY = 1'b1; cyc(); PLAY = 1'b0;
        n_tests++;
        if (playing !== 1'b1) begin
            n_fail++;
            $display("FAIL %s play_start: got playing=%b want 1", name, playing);
        end
        cyc();
        n_tests++;
        if (note_out !== 4'(exp_note[0])) begin
            n_fail++;
            $display("FAIL %s first_note: got %0d want %0d", name, note_out, exp_note[0]);
        end
        foreach (exp_note[i]) begin
            for (int d = 0; d < exp_dur[i]; d++) begin
                beat(seen);
                n_tests++;
                if (seen !== 4'(exp_note[i])) begin
                    n_fail++;
                    $display("FAIL %s entry%0d tick%0d: got %0d want %0d", name, i, d, seen, exp_note[i]);
                end
            end
        end
        cyc();
        n_tests++;
        if (playing !== 1'b0 || note_out !== 4'd0) begin
            n_fail++;
            $display("FAIL %s play_end: got playing=%b note=%0d want 0/0", name, playing, note_out);
        end
    endtask

    task automatic test_reset();
        QUARTER_BEAT = 1'b1;
        RESET = 1'b0;
        repeat (3) cyc();
        n_tests++;
        if (note_out !== 4'd0 || count !== 6'd0 || playing !== 1'b0 ||
            recording !== 1'b0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got note=%0d cnt=%0d play=%b rec=%b full=%b want all 0",
                     note_out, count, playing, recording, full);
        end
        // Beat held high across release: no tick may be seen.
        RESET = 1'b1; REC = 1'b1; cyc(); REC = 1'b0;
        n_tests++;
        if (recording !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rec_start: got %b want 1", recording);
        end
        note_in = 4'd7;
        repeat (3) cyc();
        STOP = 1'b1; cyc(); STOP = 1'b0;
        n_tests++;
        if (count !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_no_tick: got count=%0d want 0", count);
        end
        QUARTER_BEAT = 1'b0; cyc();
    endtask

    task automatic test_record_play();
        samples = '{3, 3, 5, 5, 5};
        exp_note = '{3, 5};
        exp_dur  = '{2, 3};
        exp_overflow = 1'b0;
        record("recplay");
        play_check("recplay");
    endtask

    task automatic test_saturation();
        samples.delete();
        repeat (66) samples.push_back(2);
        exp_note = '{2, 2};
        exp_dur  = '{63, 3};
        exp_overflow = 1'b0;
        record("sat");
        play_check("sat");
    endtask

    task automatic test_full();
        logic [3:0] seen;
        samples.delete();
        for (int i = 0; i < DEPTH + 1; i++) samples.push_back((i % 2) ? 2 : 1);
        model_build();
        record("full");
        note_in = 4'd9;
        repeat (2) beat(seen);
        n_tests++;
        if (count !== 6'(DEPTH) || full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_hold: got cnt=%0d full=%b want %0d/1", count, full, DEPTH);
        end
        play_check("full");
    endtask

    task automatic test_priority();
        // STOP and REC together during replay: STOP wins.
        PLAY = 1'b1; cyc(); PLAY = 1'b0; cyc();
        STOP = 1'b1; REC = 1'b1; cyc(); STOP = 1'b0; REC = 1'b0;
        n_tests++;
        if (playing !== 1'b0 || recording !== 1'b0 || note_out !== 4'd0 || count !== 6'(DEPTH)) begin
            n_fail++;
            $display("FAIL prio_stop_rec: got play=%b rec=%b note=%0d cnt=%0d want 0/0/0/%0d",
                     playing, recording, note_out, count, DEPTH);
        end
        cyc();
        n_tests++;
        if (recording !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_stays_idle: got rec=%b want 0", recording);
        end
        // PLAY with empty buffer.
        do_reset();
        PLAY = 1'b1; cyc(); PLAY = 1'b0; cyc();
        n_tests++;
        if (playing !== 1'b0) begin
            n_fail++;
            $display("FAIL play_empty: got playing=%b want 0", playing);
        end
        // PLAY during recording.
        REC = 1'b1; cyc(); REC = 1'b0;
        PLAY = 1'b1; cyc(); PLAY = 1'b0; cyc();
        n_tests++;
        if (playing !== 1'b0 || recording !== 1'b1) begin
            n_fail++;
            $display("FAIL play_in_rec: got play=%b rec=%b want 0/1", playing, recording);
        end
        STOP = 1'b1; cyc(); STOP = 1'b0; cyc();
    endtask

    task automatic test_mid_reset();
        samples = '{6, 6, 6};
        model_build();
        record("midrst");
        PLAY = 1'b1; cyc(); PLAY = 1'b0; cyc(); cyc();
        n_tests++;
        if (note_out !== 4'd6) begin
            n_fail++;
            $display("FAIL midrst_pre: got note=%0d want 6", note_out);
        end
        RESET = 1'b0; cyc(); RESET = 1'b1;
        n_tests++;
        if (note_out !== 4'd0 || count !== 6'd0 || playing !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: got note=%0d cnt=%0d play=%b want 0/0/0", note_out, count, playing);
        end
        cyc();
    endtask

    task automatic test_trim();
        samples = '{0, 0, 0, 4};
`ifdef NOTE_RECORDER_TRIM_REST_EN
        exp_note = '{4};
        exp_dur  = '{1};
`else
        exp_note = '{0, 4};
        exp_dur  = '{3, 1};
`endif
        exp_overflow = 1'b0;
        record("trim");
        play_check("trim");
    endtask

    task automatic test_random();
        int nruns;
        int nt;
        int len;
        for (int r = 0; r < 6; r++) begin
            samples.delete();
            nruns = $urandom_range(1, 10);
            for (int k = 0; k < nruns; k++) begin
                nt  = $urandom_range(0, 5);
                len = $urandom_range(1, 4);
                repeat (len) samples.push_back(nt);
            end
            model_build();
            if (exp_note.size() == 0) begin
                samples.push_back(1);
                model_build();
            end
            record($sformatf("rand%0d", r));
            play_check($sformatf("rand%0d", r));
        end
    endtask

    initial begin
        test_reset();
        test_record_play();
        test_saturation();
        test_full();
        test_priority();
        test_mid_reset();
        test_trim();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
